// File: rtl/sq_wave_gen_pkg.sv
// Shared types and constants for the square-wave / clock-enable generator.
package sq_wave_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sqw_state_e;

    localparam int SQW_CNT_W_DEF   = 32;
    localparam int SQW_BURST_W_DEF = 16;

    // Half period giving a 1 kHz wave from a 1 ns Clock.
    localparam int SQW_HP_1KHZ = 500000;

endpackage

// File: rtl/sq_wave_gen_reload_down_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module reload_down_cnt
    import sq_wave_gen_pkg::*;
#(
    parameter int W = SQW_CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Counter register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO_C;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != ZERO_C)) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == ZERO_C);

endmodule

// File: rtl/sq_wave_gen.sv
// Programmable square-wave / clock-enable generator with burst and graceful stop.
// Optional macro SQ_WAVE_GEN_DUTY_EN adds a separate high-phase length input.
module sq_wave_gen
    import sq_wave_gen_pkg::*;
#(
    parameter int CNT_W   = SQW_CNT_W_DEF,
    parameter int BURST_W = SQW_BURST_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
`ifdef SQ_WAVE_GEN_DUTY_EN
    input  logic [CNT_W-1:0]   high_period,
`endif
    input  logic [BURST_W-1:0] burst_len,
    output logic               Out,
    output logic               Out_inv,
    output logic               rise_stb,
    output logic               fall_stb,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BL_ZERO  = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] BL_ONE   = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BL_MAX   = {BURST_W{1'b1}};

    sqw_state_e         state_r;
    logic [CNT_W-1:0]   hp_r;
    logic [BURST_W-1:0] bl_r;
    logic [BURST_W-1:0] pcnt_r;
    logic               stop_pend_r;
    logic               out_r;
    logic               rise_stb_r;
    logic               fall_stb_r;
    logic               busy_r;
    logic               done_r;
`ifdef SQ_WAVE_GEN_DUTY_EN
    logic [CNT_W-1:0]   hi_r;
`endif

    logic [CNT_W-1:0]   hi_s;
    logic               hi_ok_s;
    logic               accept_s;
    logic               toggle_s;
    logic               fall_s;
    logic               burst_hit_s;
    logic               exit_s;
    logic [BURST_W-1:0] pcnt_nxt_s;
    logic               cnt_load_s;
    logic               cnt_dec_s;
    logic [CNT_W-1:0]   cnt_val_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               cnt_zero_s;

    reload_down_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk      (Clock),
        .rst      (Reset),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (cnt_val_s),
        .cnt      (cnt_s),
        .zero     (cnt_zero_s)
    );

    // High-phase length source: separate register when duty control is built in.
    always_comb begin
`ifdef SQ_WAVE_GEN_DUTY_EN
        hi_s    = hi_r;
        hi_ok_s = (high_period != CNT_ZERO);
`else
        hi_s    = hp_r;
        hi_ok_s = 1'b1;
`endif
    end

    // Phase/period decisions for the current cycle and phase-counter control.
    always_comb begin
        accept_s    = 1'b0;
        toggle_s    = 1'b0;
        fall_s      = 1'b0;
        burst_hit_s = 1'b0;
        exit_s      = 1'b0;
        pcnt_nxt_s  = pcnt_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_val_s   = CNT_ZERO;
        case (state_r)
            IDLE: begin
                if (start && (half_period != CNT_ZERO) && hi_ok_s) begin
                    accept_s   = 1'b1;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = half_period - CNT_ONE;
                end else begin
                    accept_s   = 1'b0;
                end
            end
            RUN: begin
                toggle_s = cnt_zero_s;
                fall_s   = cnt_zero_s & out_r;
                if (fall_s && (pcnt_r != BL_MAX)) begin
                    pcnt_nxt_s = pcnt_r + BL_ONE;
                end else begin
                    pcnt_nxt_s = pcnt_r;
                end
                burst_hit_s = fall_s && (bl_r != BL_ZERO) && (pcnt_nxt_s == bl_r);
                // A stop only ends the run while Out is low or on its falling edge,
                // so a high pulse is never cut short.
                exit_s = burst_hit_s
                       || (fall_s && (stop || stop_pend_r))
                       || (stop_pend_r && !out_r);
                if (exit_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_ZERO;
                end else if (toggle_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = out_r ? (hp_r - CNT_ONE) : (hi_s - CNT_ONE);
                end else begin
                    cnt_dec_s  = 1'b1;
                end
            end
            default: begin
                exit_s = 1'b1;
            end
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            hp_r        <= CNT_ZERO;
            bl_r        <= BL_ZERO;
            pcnt_r      <= BL_ZERO;
            stop_pend_r <= 1'b0;
            out_r       <= 1'b0;
            rise_stb_r  <= 1'b0;
            fall_stb_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SQ_WAVE_GEN_DUTY_EN
            hi_r        <= CNT_ZERO;
`endif
        end else begin
            rise_stb_r <= 1'b0;
            fall_stb_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= RUN;
                        hp_r        <= half_period;
                        bl_r        <= burst_len;
                        pcnt_r      <= BL_ZERO;
                        stop_pend_r <= 1'b0;
                        out_r       <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef SQ_WAVE_GEN_DUTY_EN
                        hi_r        <= high_period;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (exit_s) begin
                        state_r     <= IDLE;
                        pcnt_r      <= pcnt_nxt_s;
                        stop_pend_r <= 1'b0;
                        out_r       <= 1'b0;
                        fall_stb_r  <= out_r;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end else begin
                        if (stop) begin
                            stop_pend_r <= 1'b1;
                        end
                        if (toggle_s) begin
                            out_r      <= ~out_r;
                            rise_stb_r <= ~out_r;
                            fall_stb_r <= out_r;
                            pcnt_r     <= pcnt_nxt_s;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    out_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Out      = out_r;
    assign Out_inv  = ~out_r;
    assign rise_stb = rise_stb_r;
    assign fall_stb = fall_stb_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_sq_wave_gen.sv
// Directed scoreboard bench for sq_wave_gen; define SQ_WAVE_GEN_DUTY_EN to cover duty control.
module tb_sq_wave_gen;

    typedef struct {
        int   sc;
        int   e;
        logic o;
        logic r;
        logic f;
        logic b;
        logic d;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        Clock;
    logic        Reset;
    logic        start;
    logic        stop;
    logic [31:0] half_period;
`ifdef SQ_WAVE_GEN_DUTY_EN
    logic [31:0] high_period;
`endif
    logic [15:0] burst_len;
    logic        Out;
    logic        Out_inv;
    logic        rise_stb;
    logic        fall_stb;
    logic        busy;
    logic        done;

    sq_wave_gen dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
`ifdef SQ_WAVE_GEN_DUTY_EN
        .high_period (high_period),
`endif
        .burst_len   (burst_len),
        .Out         (Out),
        .Out_inv     (Out_inv),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .busy        (busy),
        .done        (done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic set_hp(input int hp);
        half_period = hp;
`ifdef SQ_WAVE_GEN_DUTY_EN
        high_period = hp;
`endif
    endtask

    task automatic cmp(input string tag, input int sc, input int e, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s sc%0d edge%0d observed=%b expected=%b", tag, sc, e, act, exp);
        end
    endtask

    task automatic expect_st(input int sc, input int e, input logic o, input logic r,
                             input logic f, input logic b, input logic d);
        exp_t x;
        x.sc = sc; x.e = e; x.o = o; x.r = r; x.f = f; x.b = b; x.d = d;
        sb_q.push_back(x);
    endtask

    task automatic check_now();
        exp_t x;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = sb_q.pop_front();
            cmp("Out",      x.sc, x.e, Out,      x.o);
            cmp("Out_inv",  x.sc, x.e, Out_inv,  ~x.o);
            cmp("rise_stb", x.sc, x.e, rise_stb, x.r);
            cmp("fall_stb", x.sc, x.e, fall_stb, x.f);
            cmp("busy",     x.sc, x.e, busy,     x.b);
            cmp("done",     x.sc, x.e, done,     x.d);
        end
    endtask

    task automatic step(input int sc, input int e, input logic o, input logic r,
                        input logic f, input logic b, input logic d);
        expect_st(sc, e, o, r, f, b, d);
        @(posedge Clock);
        #1;
        check_now();
    endtask

    // Continuous 50% wave, start sampled at edge 0: rise at hp, fall at 2*hp, ...
    task automatic step_cont(input int sc, input int hp, input int e);
        logic o, r, f;
        o = ((e / hp) % 2) == 1;
        r = (e > 0) && ((e % (2 * hp)) == hp);
        f = (e > 0) && ((e % (2 * hp)) == 0);
        step(sc, e, o, r, f, 1'b1, 1'b0);
    endtask

    task automatic step_idle(input int sc, input int e);
        step(sc, e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; stop = 1'b0; burst_len = 16'd0;
        set_hp(0);
        #12;
        expect_st(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now();
        Reset = 1'b0;

        // Continuous hp=4.
        set_hp(4); start = 1'b1;
        step_cont(1, 4, 0);
        start = 1'b0;
        for (int e = 1; e < 14; e++) step_cont(1, 4, e);

        // Asynchronous reset in the middle of a high phase.
        #3 Reset = 1'b1;
        #1;
        expect_st(5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now();
        #1 Reset = 1'b0;
        step_idle(5, 1);

        // Restart, then stop while Out is low: exit one edge later.
        start = 1'b1;
        step_cont(6, 4, 0);
        start = 1'b0;
        for (int e = 1; e < 17; e++) step_cont(6, 4, e);
        stop = 1'b1;
        step_cont(6, 4, 17);
        stop = 1'b0;
        step(6, 18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step_idle(6, 19);

        // Burst of 3 with hp=2; burst_len change mid-run must be ignored.
        set_hp(2); burst_len = 16'd3; start = 1'b1;
        step_cont(2, 2, 0);
        start = 1'b0; burst_len = 16'd1;
        for (int e = 1; e < 12; e++) step_cont(2, 2, e);
        step(2, 12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int e = 13; e < 16; e++) step_idle(2, e);

        // start+stop together in IDLE, then stop during the high phase.
        set_hp(5); burst_len = 16'd0; start = 1'b1; stop = 1'b1;
        step_cont(3, 5, 0);
        start = 1'b0; stop = 1'b0;
        for (int e = 1; e < 7; e++) step_cont(3, 5, e);
        stop = 1'b1;
        step_cont(3, 5, 7);
        stop = 1'b0;
        step_cont(3, 5, 8);
        step_cont(3, 5, 9);
        step(3, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int e = 11; e < 21; e++) step_idle(3, e);

        // half_period=0 is refused; then hp=1 divides by two, start during RUN ignored.
        set_hp(0); start = 1'b1;
        for (int e = 0; e < 20; e++) step_idle(4, e);
        set_hp(1);
        step_cont(7, 1, 0);
        set_hp(3); burst_len = 16'd2;
        for (int e = 1; e < 10; e++) step_cont(7, 1, e);
        start = 1'b0;
        #2 Reset = 1'b1;
        #1;
        expect_st(7, 99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now();
        #1 Reset = 1'b0;
        burst_len = 16'd0;

`ifdef SQ_WAVE_GEN_DUTY_EN
        // high_period=0 refused; then high 1 cycle, low 3 cycles.
        half_period = 3; high_period = 0; start = 1'b1;
        for (int e = 0; e < 3; e++) step_idle(8, e);
        high_period = 1;
        step(9, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int e = 1; e < 13; e++) begin
            logic o, f;
            o = (e >= 3) && (((e - 3) % 4) == 0);
            f = (e >= 4) && (((e - 4) % 4) == 0);
            step(9, e, o, o, f, 1'b1, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
